// File: rtl/fib_seq_if.sv
// Host and pipeline-link signal bundle for fib_seq_ctrl.
// master = host/pipeline environment, slave = the sequencer.
interface fib_seq_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic               cmd_go;
    logic [CNT_W-1:0]   cmd_num;
    logic               busy;
    logic               done;
    logic               err_timeout;
    logic               err_code;
    logic               err_mismatch;
    logic               fib_start;
    logic               fib_ack;
    logic [2*WIDTH-1:0] fib_out;
    logic               res_valid;
    logic [WIDTH-1:0]   res_data;
    logic [CNT_W-1:0]   res_idx;

    modport master (
        output cmd_go, cmd_num, fib_out,
        input  busy, done, err_timeout, err_code, err_mismatch,
        input  fib_start, fib_ack, res_valid, res_data, res_idx
    );

    modport slave (
        input  cmd_go, cmd_num, fib_out,
        output busy, done, err_timeout, err_code, err_mismatch,
        output fib_start, fib_ack, res_valid, res_data, res_idx
    );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Clocked sequencer for the dual-rail Fibonacci pipeline output link.
// Optional sequence checker is built when FIB_SEQ_CHECK_EN is defined.
module fib_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic     clk,
    input  logic     rst,
    fib_seq_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, WAIT_SPACER, FINISH, ERR
    } state_t;

    state_t state, state_n;

    logic [2*WIDTH-1:0] sync1, s, p;
    logic [WIDTH-1:0]   t_rail, f_rail;
    logic               is_valid, is_spacer, is_illegal;
    logic [CNT_W-1:0]   cnt, num, cnt_inc;
    logic [TW-1:0]      wdog;
    logic               wd_hit;
    logic               capture, release_ack, set_start;
    logic               to_err_to, to_err_code;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            t_rail[i] = s[2*i+1];
            f_rail[i] = s[2*i];
        end
    end

    // Classification only trusts a word that held for two synchronized samples.
    assign is_valid   = (s == p) && (&(t_rail ^ f_rail));
    assign is_spacer  = (s == '0) && (p == '0);
    assign is_illegal = (s == p) && (|(t_rail & f_rail));
    assign cnt_inc    = cnt + 1'b1;
    assign wd_hit     = (wdog == TW'(TIMEOUT - 1));

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == FINISH);

    always_comb begin
        state_n     = state;
        capture     = 1'b0;
        release_ack = 1'b0;
        set_start   = 1'b0;
        to_err_to   = 1'b0;
        to_err_code = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cmd_go) begin
                    if (bus.cmd_num == '0) begin
                        state_n = FINISH;
                    end else begin
                        set_start = 1'b1;
                        state_n   = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (is_illegal) begin
                    to_err_code = 1'b1;
                    state_n     = ERR;
                end else if (is_valid) begin
                    capture = 1'b1;
                    state_n = WAIT_SPACER;
                end else if (wd_hit) begin
                    to_err_to = 1'b1;
                    state_n   = ERR;
                end
            end
            WAIT_SPACER: begin
                if (is_illegal) begin
                    to_err_code = 1'b1;
                    state_n     = ERR;
                end else if (is_spacer) begin
                    release_ack = 1'b1;
                    state_n = (cnt_inc == num) ? FINISH : WAIT_DATA;
                end else if (wd_hit) begin
                    to_err_to = 1'b1;
                    state_n   = ERR;
                end
            end
            FINISH:  state_n = IDLE;
            ERR:     state_n = ERR;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            sync1           <= '0;
            s               <= '0;
            p               <= '0;
            cnt             <= '0;
            num             <= '0;
            wdog            <= '0;
            bus.fib_start   <= 1'b0;
            bus.fib_ack     <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.res_data    <= '0;
            bus.res_idx     <= '0;
            bus.err_timeout <= 1'b0;
            bus.err_code    <= 1'b0;
        end else begin
            state         <= state_n;
            sync1         <= bus.fib_out;
            s             <= sync1;
            p             <= s;
            bus.res_valid <= capture;
            if (state_n != state) begin
                wdog <= '0;
            end else if (state == WAIT_DATA || state == WAIT_SPACER) begin
                wdog <= wdog + 1'b1;
            end
            if (set_start) begin
                num           <= bus.cmd_num;
                cnt           <= '0;
                bus.fib_start <= 1'b1;
            end
            if (capture) begin
                bus.res_data <= t_rail;
                bus.res_idx  <= cnt;
                bus.fib_ack  <= 1'b1;
            end
            if (release_ack) begin
                bus.fib_ack <= 1'b0;
                cnt         <= cnt_inc;
            end
            if (state_n == FINISH || state_n == ERR) begin
                bus.fib_start <= 1'b0;
            end
            if (to_err_to) begin
                bus.err_timeout <= 1'b1;
            end
            if (to_err_code) begin
                bus.err_code <= 1'b1;
            end
        end
    end

`ifdef FIB_SEQ_CHECK_EN
    logic [WIDTH-1:0] chk_a, chk_b;

    // Checker runs the recurrence itself and survives across runs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chk_a            <= '0;
            chk_b            <= WIDTH'(1);
            bus.err_mismatch <= 1'b0;
        end else if (capture) begin
            if (t_rail != chk_a) begin
                bus.err_mismatch <= 1'b1;
            end
            chk_a <= chk_b;
            chk_b <= chk_a + chk_b;
        end
    end
`else
    assign bus.err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl with a behavioural dual-rail pipeline.
module tb_fib_seq_ctrl;
    localparam int WIDTH   = 16;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fib_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    fib_seq_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2*WIDTH-1:0] pipe_rails;
    logic [2*WIDTH-1:0] glitch_rails;
    assign bus.fib_out = pipe_rails | glitch_rails;

    logic [WIDTH-1:0] fa, fb;
    bit presenting;
    bit pipe_en;
    int dly;
    int sent;
    int hold_at;
    int gidx;

    logic [WIDTH-1:0] cap_d[$];
    logic [CNT_W-1:0] cap_i[$];
    bit start_seen;
    int n_ack_bad = 0;
    logic ack_q = 1'b0;
    bit ack_chg_q = 1'b0;

    function automatic logic [WIDTH-1:0] fib(input int n);
        logic [WIDTH-1:0] a, b, t;
        a = '0;
        b = WIDTH'(1);
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pipe_reset();
        fa         = '0;
        fb         = WIDTH'(1);
        presenting = 1'b0;
        pipe_rails = '0;
        dly        = 0;
        sent       = 0;
        hold_at    = -1;
    endtask

    // Behavioural four-phase pipeline: word on !ack, spacer on ack.
    initial begin
        forever begin
            @(negedge clk);
            if (pipe_en) begin
                if (!presenting) begin
                    if (bus.fib_start === 1'b1 && bus.fib_ack === 1'b0 &&
                        (hold_at < 0 || sent < hold_at)) begin
                        if (dly == 0) begin
                            pipe_rails = enc(fa);
                            {fa, fb}   = {fb, fa + fb};
                            sent++;
                            presenting = 1'b1;
                            dly        = $urandom_range(0, 3);
                        end else begin
                            dly--;
                        end
                    end
                end else if (bus.fib_ack === 1'b1) begin
                    if (dly == 0) begin
                        pipe_rails = '0;
                        presenting = 1'b0;
                        dly        = $urandom_range(0, 3);
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.res_valid === 1'b1) begin
            cap_d.push_back(bus.res_data);
            cap_i.push_back(bus.res_idx);
        end
        if (bus.fib_start === 1'b1) start_seen = 1'b1;
        if (bus.fib_ack !== ack_q && ack_chg_q) n_ack_bad++;
        ack_chg_q = (bus.fib_ack !== ack_q);
        ack_q     = bus.fib_ack;
    end

    task automatic go(input int num);
        @(posedge clk); #1;
        bus.cmd_go  = 1'b1;
        bus.cmd_num = CNT_W'(num);
        @(posedge clk); #1;
        bus.cmd_go  = 1'b0;
    endtask

    task automatic run(input int num);
        bit got;
        cap_d.delete();
        cap_i.delete();
        start_seen = 1'b0;
        go(num);
        chk("go_busy", bus.busy, 1);
        chk("go_start", bus.fib_start, num != 0);
        chk("go_done", bus.done, num == 0);
        got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = 1'b1;
        end
        chk("run_done_seen", got, 1);
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        chk("busy_fall", bus.busy, 0);
        chk("start_seen", start_seen, num != 0);
        chk("run_count", cap_d.size(), num);
        for (int i = 0; i < num && i < cap_d.size(); i++) begin
            chk("run_data", cap_d[i], fib(gidx + i));
            chk("run_idx", cap_i[i], i);
        end
        gidx += num;
        chk("run_err_timeout", bus.err_timeout, 0);
        chk("run_err_code", bus.err_code, 0);
        chk("run_err_mismatch", bus.err_mismatch, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.cmd_go   = 1'b0;
        glitch_rails = '0;
        pipe_en      = 1'b1;
        pipe_reset();
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        gidx = 0;
    endtask

    initial begin
        int n;
        int nv;
        bit got;
        bus.cmd_go   = 1'b0;
        bus.cmd_num  = '0;
        glitch_rails = '0;
        pipe_en      = 1'b1;
        pipe_reset();
        gidx = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_start", bus.fib_start, 0);
        chk("rst_ack", bus.fib_ack, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_data", bus.res_data, 0);
        chk("rst_idx", bus.res_idx, 0);
        chk("rst_err_timeout", bus.err_timeout, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_err_mismatch", bus.err_mismatch, 0);
        rst = 1'b1;

        run(8);
        run(3);
        run(0);
        for (int r = 0; r < 3; r++) run($urandom_range(1, 6));

        // Watchdog: pipeline stalls after two more words.
        cap_d.delete();
        cap_i.delete();
        hold_at = sent + 2;
        go(5);
        nv  = 0;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) nv++;
            if (nv == 2 && bus.fib_ack === 1'b0) got = 1'b1;
        end
        chk("to_entry_seen", got, 1);
        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            n++;
            if (bus.err_timeout === 1'b1) got = 1'b1;
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_start", bus.fib_start, 0);
        chk("to_busy", bus.busy, 1);
        chk("to_code", bus.err_code, 0);
        chk("to_count", cap_d.size(), 2);
        if (cap_d.size() == 2) begin
            chk("to_data0", cap_d[0], fib(gidx));
            chk("to_data1", cap_d[1], fib(gidx + 1));
        end
        go(3);
        repeat (3) @(posedge clk);
        #1;
        chk("err_go_busy", bus.busy, 1);
        chk("err_go_start", bus.fib_start, 0);
        do_reset();
        chk("to_cleared", bus.err_timeout, 0);

        // Illegal code: one-cycle glitch ignored, three-cycle hold trapped.
        cap_d.delete();
        cap_i.delete();
        hold_at = sent;
        go(2);
        glitch_rails = '0;
        glitch_rails[11:10] = 2'b11;
        @(posedge clk); #1;
        glitch_rails = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("glitch_code", bus.err_code, 0);
        chk("glitch_busy", bus.busy, 1);
        glitch_rails[11:10] = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        glitch_rails = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("ill_code", bus.err_code, 1);
        chk("ill_timeout", bus.err_timeout, 0);
        chk("ill_no_valid", cap_d.size(), 0);
        chk("ill_start", bus.fib_start, 0);
        chk("ill_busy", bus.busy, 1);
        do_reset();

        // Mid-run reset while ack is high.
        go(8);
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.fib_ack === 1'b1) got = 1'b1;
        end
        chk("mr_ack_seen", got, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_ack", bus.fib_ack, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_start", bus.fib_start, 0);
        chk("mr_idx", bus.res_idx, 0);
        pipe_reset();
        gidx = 0;
        rst  = 1'b1;
        run(4);

        // Exact capture/release latency with a hand-driven link.
        pipe_en = 1'b0;
        go(1);
        repeat (2) @(posedge clk);
        #1;
        pipe_rails = enc(fib(gidx));
        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) got = 1'b1;
            else n++;
        end
        chk("lat_cap", n, 4);
        chk("lat_ack_up", bus.fib_ack, 1);
        chk("lat_data", bus.res_data, fib(gidx));
        @(posedge clk); #1;
        pipe_rails = '0;
        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.fib_ack === 1'b0) got = 1'b1;
            else n++;
        end
        chk("lat_rel", n, 4);
        chk("lat_done", bus.done, 1);
        @(negedge clk);
        chk("lat_busy_fall", bus.busy, 0);
        chk("end_mismatch", bus.err_mismatch, 0);
        chk("ack_min_phase", n_ack_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
